// File: rtl/torect.sv
// rtl/torect.sv - Pipelined rotation-mode CORDIC, polar (mag, phase Q3.29) to rectangular (x, y).
// Optional unity-gain output stage: define TORECT_GAIN_COMP_EN.
module torect #(
  parameter int WIDTH   = 32,
  parameter int NSTAGES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_mag,
  input  logic [31:0]      i_phase,
  output logic             o_vld,
  output logic [WIDTH:0]   o_x,
  output logic [WIDTH:0]   o_y
);

  localparam logic signed [31:0] PI      = 32'sh6487ED51;
  localparam logic signed [31:0] HALF_PI = 32'sh3243F6A9;

  // round(atan(2^-i) * 2^29)
  function automatic logic signed [31:0] atan_tab(input int i);
    case (i)
      0:       return 32'sh1921FB54;
      1:       return 32'sh0ED63383;
      2:       return 32'sh07D6DD7E;
      3:       return 32'sh03FAB753;
      4:       return 32'sh01FF55BB;
      5:       return 32'sh00FFEAAE;
      6:       return 32'sh007FFD55;
      7:       return 32'sh003FFFAB;
      8:       return 32'sh001FFFF5;
      9:       return 32'sh000FFFFF;
      10:      return 32'sh00080000;
      11:      return 32'sh00040000;
      12:      return 32'sh00020000;
      13:      return 32'sh00010000;
      14:      return 32'sh00008000;
      15:      return 32'sh00004000;
      default: return 32'sh00000000;
    endcase
  endfunction

  logic signed [WIDTH+1:0] mag_ext;
  logic signed [31:0]      phase_s;
  logic signed [WIDTH+1:0] x0_d;
  logic signed [31:0]      z0_d;

  logic signed [WIDTH+1:0] x_q [0:NSTAGES];
  logic signed [WIDTH+1:0] y_q [0:NSTAGES];
  logic signed [31:0]      z_q [0:NSTAGES];
  logic [NSTAGES:0]        vld_q;

  assign mag_ext = {{2{i_mag[WIDTH-1]}}, i_mag};
  assign phase_s = i_phase;

  // Fold phases outside [-pi/2, pi/2] by pi and negate the vector to compensate.
  always_comb begin
    x0_d = mag_ext;
    z0_d = phase_s;
    if (phase_s > HALF_PI) begin
      x0_d = -mag_ext;
      z0_d = phase_s - PI;
    end else if (phase_s < -HALF_PI) begin
      x0_d = -mag_ext;
      z0_d = phase_s + PI;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k <= NSTAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
      end
    end else begin
      vld_q <= {vld_q[NSTAGES-1:0], i_vld};
      if (i_vld) begin
        x_q[0] <= x0_d;
        y_q[0] <= '0;
        z_q[0] <= z0_d;
      end
      for (int k = 1; k <= NSTAGES; k++) begin
        if (vld_q[k-1]) begin
          if (!z_q[k-1][31]) begin
            x_q[k] <= x_q[k-1] - (y_q[k-1] >>> (k-1));
            y_q[k] <= y_q[k-1] + (x_q[k-1] >>> (k-1));
            z_q[k] <= z_q[k-1] - atan_tab(k-1);
          end else begin
            x_q[k] <= x_q[k-1] + (y_q[k-1] >>> (k-1));
            y_q[k] <= y_q[k-1] - (x_q[k-1] >>> (k-1));
            z_q[k] <= z_q[k-1] + atan_tab(k-1);
          end
        end
      end
    end
  end

`ifdef TORECT_GAIN_COMP_EN
  // 1/K in Q1.30, rounded half-up before the shift back to integer scale.
  localparam logic signed [WIDTH+33:0] GAIN_INV = (WIDTH+34)'(32'sh26DD3B6A);
  localparam logic signed [WIDTH+33:0] RND      = (WIDTH+34)'(32'sh20000000);

  logic             gv_q;
  logic [WIDTH:0]   gx_q;
  logic [WIDTH:0]   gy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gv_q <= 1'b0;
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gv_q <= vld_q[NSTAGES];
      if (vld_q[NSTAGES]) begin
        gx_q <= (WIDTH+1)'(((WIDTH+34)'(x_q[NSTAGES]) * GAIN_INV + RND) >>> 30);
        gy_q <= (WIDTH+1)'(((WIDTH+34)'(y_q[NSTAGES]) * GAIN_INV + RND) >>> 30);
      end
    end
  end

  assign o_vld = gv_q;
  assign o_x   = gx_q;
  assign o_y   = gy_q;
`else
  // Gain stays below 2, so the top guard bit is always a sign copy.
  assign o_vld = vld_q[NSTAGES];
  assign o_x   = x_q[NSTAGES][WIDTH:0];
  assign o_y   = y_q[NSTAGES][WIDTH:0];
`endif

endmodule

// File: tb/tb_torect.sv
// tb/tb_torect.sv - Directed self-checking bench for torect (honours TORECT_GAIN_COMP_EN).
module tb_torect;
  localparam int W  = 32;
  localparam int NS = 16;
`ifdef TORECT_GAIN_COMP_EN
  localparam int  LAT  = NS + 2;
  localparam real KEFF = 1.0;
`else
  localparam int  LAT  = NS + 1;
  localparam real KEFF = 1.6467602581210656;
`endif
  // Residual angle bound atan(2^-15) rounded up, applied to the full output magnitude.
  localparam real RESID = 3.06e-5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_vld = 1'b0;
  logic [W-1:0] i_mag = '0;
  logic [31:0]  i_phase = '0;
  logic         o_vld;
  logic [W:0]   o_x;
  logic [W:0]   o_y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  torect #(.WIDTH(W), .NSTAGES(NS)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_mag(i_mag), .i_phase(i_phase),
    .o_vld(o_vld), .o_x(o_x), .o_y(o_y)
  );

  function automatic real ang(input logic [31:0] p);
    return $itor($signed(p)) / 536870912.0;
  endfunction

  function automatic real sval(input logic [W:0] v);
    longint t;
    t = longint'($signed(v));
    return real'(t);
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real tol_for(input logic [W-1:0] m);
    return KEFF * rabs($itor($signed(m))) * RESID + 4.0;
  endfunction

  task automatic run_one(input logic [W-1:0] m, input logic [31:0] p,
                         output logic [W:0] x, output logic [W:0] y, output int lat);
    @(negedge clk);
    i_vld = 1'b1; i_mag = m; i_phase = p;
    lat = -1;
    for (int c = 1; c <= LAT + 10; c++) begin
      @(negedge clk);
      i_vld = 1'b0;
      if (o_vld) begin
        lat = c;
        break;
      end
    end
    x = o_x; y = o_y;
  endtask

  task automatic test_reset;
    logic [W:0] x, y;
    int lat;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_vld, o_x, o_y} !== '0) begin
        n_bad++;
        $display("FAIL reset_hold cyc %0d: vld=%0b x=%0h y=%0h want all 0", c, o_vld, o_x, o_y);
      end
      i_vld = 1'($urandom_range(0, 1)); i_mag = $urandom; i_phase = $urandom;
    end
    @(negedge clk);
    rst = 1'b1; i_vld = 1'b0;
    repeat (3) @(negedge clk);
    run_one(32'h0010_0000, 32'h0, x, y, lat);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("FAIL reset_first_latency: got %0d want %0d", lat, LAT);
    end
  endtask

  task automatic test_cardinal;
    logic [W-1:0] mv [2] = '{32'h0010_0000, 32'h0010_0000};
    logic [31:0]  pv [2] = '{32'h0000_0000, 32'h3243_F6A9};
    logic [W:0] x, y;
    int lat;
    real ex, ey, tl;
    for (int i = 0; i < 2; i++) begin
      run_one(mv[i], pv[i], x, y, lat);
      ex = KEFF * $itor($signed(mv[i])) * $cos(ang(pv[i]));
      ey = KEFF * $itor($signed(mv[i])) * $sin(ang(pv[i]));
      tl = tol_for(mv[i]);
      n_cmp++;
      if (lat !== LAT) begin n_bad++; $display("FAIL cardinal[%0d] latency: got %0d want %0d", i, lat, LAT); end
      n_cmp++;
      if (rabs(sval(x) - ex) > tl) begin n_bad++; $display("FAIL cardinal[%0d] x: got %0d want %0.1f+-%0.1f", i, $signed(x), ex, tl); end
      n_cmp++;
      if (rabs(sval(y) - ey) > tl) begin n_bad++; $display("FAIL cardinal[%0d] y: got %0d want %0.1f+-%0.1f", i, $signed(y), ey, tl); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (rabs(sval(o_x) - ex) > tl || rabs(sval(o_y) - ey) > tl) begin
        n_bad++;
        $display("FAIL cardinal[%0d] hold: got x=%0d y=%0d want %0.1f,%0.1f", i, $signed(o_x), $signed(o_y), ex, ey);
      end
    end
  endtask

  task automatic test_fold;
    logic [31:0] pv [3] = '{32'h6487_ED51, 32'hB49A_0E3D, 32'h9B78_12AF};
    logic [W:0] x, y;
    int lat;
    real ex, ey, tl;
    for (int i = 0; i < 3; i++) begin
      run_one(32'h0010_0000, pv[i], x, y, lat);
      ex = KEFF * 1048576.0 * $cos(ang(pv[i]));
      ey = KEFF * 1048576.0 * $sin(ang(pv[i]));
      tl = tol_for(32'h0010_0000);
      n_cmp++;
      if (rabs(sval(x) - ex) > tl) begin n_bad++; $display("FAIL fold[%0d] x: got %0d want %0.1f+-%0.1f", i, $signed(x), ex, tl); end
      n_cmp++;
      if (rabs(sval(y) - ey) > tl) begin n_bad++; $display("FAIL fold[%0d] y: got %0d want %0.1f+-%0.1f", i, $signed(y), ey, tl); end
    end
  endtask

  task automatic test_full_scale;
    logic [W-1:0] mv [2] = '{32'h7FFF_FFFF, 32'h8000_0001};
    logic [W:0] x, y;
    int lat;
    real ex, tl;
    for (int i = 0; i < 2; i++) begin
      run_one(mv[i], 32'h0, x, y, lat);
      ex = KEFF * $itor($signed(mv[i]));
      tl = tol_for(mv[i]) + 8.0;
      n_cmp++;
      if (rabs(sval(x) - ex) > tl) begin n_bad++; $display("FAIL full_scale[%0d] x: got %0d want %0.1f+-%0.1f", i, $signed(x), ex, tl); end
      n_cmp++;
      if (x[W] !== mv[i][W-1]) begin n_bad++; $display("FAIL full_scale[%0d] sign: got %0b want %0b", i, x[W], mv[i][W-1]); end
    end
  endtask

  task automatic test_stream;
    bit  in_h[$];
    bit  out_h[$];
    real ex_q[$], ey_q[$], tl_q[$];
    int  sent = 0, got = 0, tail = 0, mism = 0;
    int  mi;
    longint pl;
    real ex, ey, tl;
    for (int t = 0; t < 400 && tail < LAT + 5; t++) begin
      @(negedge clk);
      out_h.push_back(o_vld);
      if (o_vld) begin
        got++;
        if (ex_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stream unexpected output at cycle %0d", t);
        end else begin
          ex = ex_q.pop_front(); ey = ey_q.pop_front(); tl = tl_q.pop_front();
          n_cmp++;
          if (rabs(sval(o_x) - ex) > tl || rabs(sval(o_y) - ey) > tl) begin
            n_bad++;
            $display("FAIL stream sample %0d: got x=%0d y=%0d want %0.1f,%0.1f +-%0.1f", got, $signed(o_x), $signed(o_y), ex, ey, tl);
          end
        end
      end
      if (sent < 40 && $urandom_range(0, 2) != 0) begin
        mi = int'($urandom_range(0, 2097152)) - 1048576;
        pl = longint'($urandom_range(0, 32'hC90F_DAA2)) - 64'sh6487_ED51;
        i_vld = 1'b1; i_mag = mi; i_phase = pl[31:0];
        ex_q.push_back(KEFF * $itor(mi) * $cos(ang(i_phase)));
        ey_q.push_back(KEFF * $itor(mi) * $sin(ang(i_phase)));
        tl_q.push_back(tol_for(i_mag));
        sent++;
      end else begin
        i_vld = 1'b0;
        if (sent == 40) tail++;
      end
      in_h.push_back(i_vld);
    end
    for (int t = 0; t < out_h.size(); t++)
      if (out_h[t] !== ((t >= LAT) ? in_h[t-LAT] : 1'b0)) mism++;
    n_cmp++;
    if (mism != 0) begin n_bad++; $display("FAIL stream vld_pattern: %0d cycles differ, want 0", mism); end
    n_cmp++;
    if (got != 40) begin n_bad++; $display("FAIL stream count: got %0d want 40", got); end
  endtask

  task automatic test_reset_midstream;
    logic [W:0] x, y;
    int lat, stale = 0;
    real ex, ey, tl;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i_vld = 1'b1; i_mag = 32'h0004_0000; i_phase = 32'h1000_0000;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_vld, o_x, o_y} !== '0) begin n_bad++; $display("FAIL midreset_async: vld=%0b x=%0h y=%0h want all 0", o_vld, o_x, o_y); end
    repeat (3) begin
      @(negedge clk);
      i_vld = 1'($urandom_range(0, 1));
      n_cmp++;
      if ({o_vld, o_x, o_y} !== '0) begin n_bad++; $display("FAIL midreset_hold: vld=%0b x=%0h y=%0h want all 0", o_vld, o_x, o_y); end
    end
    @(negedge clk);
    rst = 1'b1; i_vld = 1'b0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge clk);
      if (o_vld) stale++;
    end
    n_cmp++;
    if (stale != 0) begin n_bad++; $display("FAIL midreset_stale: %0d stale outputs, want 0", stale); end
    run_one(32'h0008_0000, 32'hCDBC_0957, x, y, lat);
    ex = KEFF * 524288.0 * $cos(ang(32'hCDBC_0957));
    ey = KEFF * 524288.0 * $sin(ang(32'hCDBC_0957));
    tl = tol_for(32'h0008_0000);
    n_cmp++;
    if (lat !== LAT) begin n_bad++; $display("FAIL midreset_latency: got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (rabs(sval(x) - ex) > tl || rabs(sval(y) - ey) > tl) begin
      n_bad++;
      $display("FAIL midreset_sample: got x=%0d y=%0d want %0.1f,%0.1f +-%0.1f", $signed(x), $signed(y), ex, ey, tl);
    end
  endtask

  initial begin
    test_reset;
    test_cardinal;
    test_fold;
    test_full_scale;
    test_stream;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
